firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench

//  Ownership controller for one tessent_data_mux instance (3-bit IJTAG/functional data mux).

---
 rtl/firebird7_in_gate1_tessent_mux_ctrl_pkg.sv | 14 +
 rtl/firebird7_in_gate1_tessent_data_mux_w3_11.sv | 15 +
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 126 ++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_pkg.sv
// Shared types and defaults for the tessent_data_mux ownership controller.
package firebird7_in_gate1_tessent_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        GUARD,
        OWN,
        RELEASE
    } mux_ctrl_state_e;

    localparam int MUX_CTRL_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_w3_11.sv
// IJTAG/functional data mux: select=1 routes the IJTAG shadow data to the output.
module firebird7_in_gate1_tessent_data_mux_w3_11
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH = MUX_CTRL_WIDTH_DEFAULT
) (
    input  logic             ijtag_select,
    input  logic [WIDTH-1:0] ijtag_data_in,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic [WIDTH-1:0] data_out
);

    assign data_out = ijtag_select ? ijtag_data_in : functional_data_in;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Ownership controller for one tessent_data_mux: drains the functional side, inserts
// guard gaps around select changes, and shadows IJTAG data behind the update pulse.
module firebird7_in_gate1_tessent_data_mux_ctrl
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH        = MUX_CTRL_WIDTH_DEFAULT,
    parameter int GUARD_CYCLES = 4,
    parameter int DRAIN_MAX    = 255
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_req,
    input  logic             ijtag_update,
    input  logic [WIDTH-1:0] ijtag_data_in,
    input  logic             func_busy,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             func_hold,
    output logic             ijtag_grant,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] data_out,
    output logic             drain_timeout
);

    localparam int DCW = $clog2(DRAIN_MAX + 1);
    localparam int GCW = $clog2(GUARD_CYCLES + 1);

    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);
    localparam logic [GCW-1:0] GUARD_LOAD = GCW'(GUARD_CYCLES - 1);
    localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
    localparam logic [GCW-1:0] GUARD_ONE  = GCW'(1);

    mux_ctrl_state_e  state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [GCW-1:0]   guard_cnt_q, guard_cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             drain_timeout_q, drain_timeout_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        guard_cnt_d     = guard_cnt_q;
        drain_timeout_d = drain_timeout_q;
        shadow_d        = ijtag_update ? ijtag_data_in : shadow_q;

        unique case (state_q)
            IDLE: begin
                if (ijtag_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!ijtag_req) begin
                    state_d = IDLE;
                end else if (!func_busy) begin
                    state_d     = GUARD;
                    guard_cnt_d = GUARD_LOAD;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d         = IDLE;
                    drain_timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_ONE;
                end
            end
            GUARD: begin
                if (!ijtag_req) begin
                    state_d = IDLE;
                end else if (guard_cnt_q == '0) begin
                    state_d = OWN;
                end else begin
                    guard_cnt_d = guard_cnt_q - GUARD_ONE;
                end
            end
            OWN: begin
                if (!ijtag_req) begin
                    state_d     = RELEASE;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            RELEASE: begin
                // A re-request is deliberately deferred until IDLE so the gap is always full length.
                if (guard_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - GUARD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        func_hold    = (state_q != IDLE);
        ijtag_select = (state_q == OWN);
        ijtag_grant  = (state_q == OWN);
    end

    always_ff @(posedge ijtag_tck) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (ijtag_reset) begin
            state_q         <= IDLE;
            drain_cnt_q     <= '0;
            guard_cnt_q     <= '0;
            // NOTE: the shadow is reset because it reaches data_out as soon as select rises.
            shadow_q        <= '0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            drain_cnt_q     <= drain_cnt_d;
            guard_cnt_q     <= guard_cnt_d;
            shadow_q        <= shadow_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign drain_timeout = drain_timeout_q;

    firebird7_in_gate1_tessent_data_mux_w3_11 #(
        .WIDTH(WIDTH)
    ) u_data_mux (
        .ijtag_select      (ijtag_select),
        .ijtag_data_in     (shadow_q),
        .functional_data_in(functional_data_in),
        .data_out          (data_out)
    );

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed bench: expectations are queued with the cycle they are due and checked as the run reaches it.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst, req, upd, busy, req2, busy2;
    logic [2:0] din, fdin;

    logic       hold, grant, sel, tmo;
    logic [2:0] dout;
    logic       hold2, grant2, sel2, tmo2;
    logic [2:0] dout2;

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3), .GUARD_CYCLES(4), .DRAIN_MAX(255)
    ) dut (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_req(req), .ijtag_update(upd),
        .ijtag_data_in(din), .func_busy(busy), .functional_data_in(fdin),
        .func_hold(hold), .ijtag_grant(grant), .ijtag_select(sel),
        .data_out(dout), .drain_timeout(tmo)
    );

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3), .GUARD_CYCLES(4), .DRAIN_MAX(8)
    ) dut_short (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_req(req2), .ijtag_update(upd),
        .ijtag_data_in(din), .func_busy(busy2), .functional_data_in(fdin),
        .func_hold(hold2), .ijtag_grant(grant2), .ijtag_select(sel2),
        .data_out(dout2), .drain_timeout(tmo2)
    );

    typedef struct {
        int         due;
        int         which;
        string      tag;
        logic [6:0] v;      // {select, grant, hold, timeout, data_out}
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic void push(int due, int which, string tag,
                                 logic s, logic g, logic h, logic t, logic [2:0] d);
        exp_t e;
        e.due   = due;
        e.which = which;
        e.tag   = tag;
        e.v     = {s, g, h, t, d};
        sb.push_back(e);
    endfunction

    task automatic check();
        logic [6:0] obs;
        int i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                obs = (sb[i].which == 0) ? {sel, grant, hold, tmo, dout}
                                         : {sel2, grant2, hold2, tmo2, dout2};
                total++;
                assert (obs === sb[i].v)
                else begin
                    bad++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, cyc, obs, sb[i].v);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check();
    endtask

    initial begin
        int c, n, m, k, b, t;
        rst = 1'b1; req = 1'b0; upd = 1'b0; busy = 1'b0; req2 = 1'b0; busy2 = 1'b0;
        din = 3'b000; fdin = 3'b010;
        tick();
        tick();

        // Reset state on both instances
        rst = 1'b0;
        push(cyc + 1, 0, "rst_state", 0, 0, 0, 0, 3'b010);
        push(cyc + 1, 1, "rst_state_short", 0, 0, 0, 0, 3'b010);
        tick();

        // 1: takeover with busy=0, update loaded alongside the request
        c = cyc;
        req = 1'b1; upd = 1'b1; din = 3'b101; busy = 1'b0;
        for (int i = 1; i <= 5; i++) push(c + i, 0, "t1_pre_own", 0, 0, 1, 0, 3'b010);
        push(c + 6, 0, "t1_own", 1, 1, 1, 0, 3'b101);
        push(c + 7, 0, "t1_own_hold", 1, 1, 1, 0, 3'b101);
        tick();
        upd = 1'b0; din = 3'b000;
        repeat (7) tick();

        // 4: release with symmetric guard; re-request during RELEASE deferred to IDLE
        n = cyc;
        req = 1'b0;
        for (int i = 1; i <= 4; i++) push(n + i, 0, "t4_release", 0, 0, 1, 0, 3'b010);
        push(n + 5, 0, "t4_idle", 0, 0, 0, 0, 3'b010);
        push(n + 6, 0, "t4_redrain", 0, 0, 1, 0, 3'b010);
        push(n + 11, 0, "t4_reown", 1, 1, 1, 0, 3'b101);
        tick();
        tick();
        req = 1'b1;
        repeat (9) tick();

        // 6: update every cycle in OWN, data_out follows one cycle later
        for (int i = 0; i < 8; i++) begin
            upd = 1'b1;
            din = 3'(i);
            push(cyc + 1, 0, "t6_follow", 1, 1, 1, 0, 3'(i));
            tick();
        end
        upd = 1'b0; din = 3'b000;
        push(cyc + 1, 0, "t6_hold_last", 1, 1, 1, 0, 3'b111);
        tick();

        // 5b: reset mid-OWN drops everything next cycle and clears the shadow
        m = cyc;
        rst = 1'b1; fdin = 3'b110;
        push(m + 1, 0, "t5_reset_own", 0, 0, 0, 0, 3'b110);
        push(m + 1, 1, "t5_reset_short", 0, 0, 0, 0, 3'b110);
        push(m + 2, 0, "t5_retake_drain", 0, 0, 1, 0, 3'b110);
        for (int i = 3; i <= 6; i++) push(m + i, 0, "t5_retake_guard", 0, 0, 1, 0, 3'b110);
        push(m + 7, 0, "t5_shadow_zero", 1, 1, 1, 0, 3'b000);
        push(m + 12, 0, "t5_back_idle", 0, 0, 0, 0, 3'b110);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        req = 1'b0;
        repeat (5) tick();

        // 5a: request dropped mid-GUARD aborts with no select pulse
        k = cyc;
        req = 1'b1;
        for (int i = 1; i <= 3; i++) push(k + i, 0, "t5_guard_hold", 0, 0, 1, 0, 3'b110);
        for (int i = 4; i <= 8; i++) push(k + i, 0, "t5_guard_abort", 0, 0, 0, 0, 3'b110);
        tick();
        tick();
        tick();
        req = 1'b0;
        repeat (5) tick();

        // 2: busy high for 10 cycles defers GUARD until the busy=0 sample
        b = cyc;
        req = 1'b1; busy = 1'b1;
        for (int i = 1; i <= 14; i++) push(b + i, 0, "t2_wait", 0, 0, 1, 0, 3'b110);
        push(b + 15, 0, "t2_own", 1, 1, 1, 0, 3'b000);
        repeat (10) tick();
        busy = 1'b0;
        repeat (5) tick();
        req = 1'b0;
        repeat (6) tick();

        // 3: DRAIN_MAX=8 abort, sticky timeout, automatic retry while req stays high
        t = cyc;
        req2 = 1'b1; busy2 = 1'b1;
        for (int i = 1; i <= 8; i++) push(t + i, 1, "t3_drain", 0, 0, 1, 0, 3'b110);
        push(t + 9, 1, "t3_abort", 0, 0, 0, 1, 3'b110);
        for (int i = 10; i <= 17; i++) push(t + i, 1, "t3_retry", 0, 0, 1, 1, 3'b110);
        push(t + 18, 1, "t3_abort2", 0, 0, 0, 1, 3'b110);
        push(t + 19, 1, "t3_retry2", 0, 0, 1, 1, 3'b110);
        push(t + 20, 1, "t3_sticky", 0, 0, 0, 1, 3'b110);
        push(t + 25, 1, "t3_sticky_late", 0, 0, 0, 1, 3'b110);
        repeat (19) tick();
        req2 = 1'b0;
        repeat (6) tick();

        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s due=%0d never reached observed=none expected=%b", sb[0].tag, sb[0].due, sb[0].v);
            sb.delete(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
